// File: rtl/pipe_perf_mon.sv
// pipe_perf_mon: per-channel hazard event counters, a free-running cycle counter,
// a timestamped first-word-fall-through trace FIFO and a registered debug readout.
module pipe_perf_mon #(
    parameter int NUM_EVT     = 4,
    parameter int CNT_W       = 32,
    parameter int TRACE_DEPTH = 16,
    parameter int SATURATE    = 0
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               enable,
    input  logic               clear,
    input  logic [NUM_EVT-1:0] evt_i,
    input  logic [4:0]         rd_sel,
    output logic [CNT_W-1:0]   rd_data,
    output logic               trace_valid,
    input  logic               trace_ready,
    output logic [CNT_W-1:0]   trace_cycle,
    output logic [NUM_EVT-1:0] trace_evt,
    output logic               trace_drop
);
    localparam int PTR_W = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;
    localparam int OCC_W = $clog2(TRACE_DEPTH + 1);
    localparam int REC_W = CNT_W + NUM_EVT;
    localparam logic [CNT_W-1:0] ALL_ONES   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [OCC_W-1:0] OCC_FULL   = OCC_W'(TRACE_DEPTH);
    localparam logic [OCC_W-1:0] OCC_ONE    = OCC_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [4:0]       SEL_STATUS = 5'(NUM_EVT + 1);

    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] evt_cnt [NUM_EVT];
    logic [NUM_EVT:0] ovf;
    logic [REC_W-1:0] mem [TRACE_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;
    logic             full;
    logic             push_req;
    logic             do_push;
    logic             do_pop;
    logic [REC_W-1:0] head;
    logic [CNT_W-1:0] status;
    logic [CNT_W-1:0] rd_next;

    // All-ones either wraps to zero or sticks, depending on the overflow mode.
    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
        if (v == ALL_ONES) begin
            return (SATURATE != 0) ? ALL_ONES : '0;
        end
        return v + CNT_ONE;
    endfunction

    assign trace_valid = (occ != '0);
    assign head        = mem[rd_ptr];
    assign {trace_cycle, trace_evt} = trace_valid ? head : '0;

    always_comb begin
        full     = (occ == OCC_FULL);
        do_pop   = trace_valid && trace_ready;
        push_req = enable && (evt_i != '0);
        do_push  = push_req && (!full || do_pop);
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            cycle_cnt <= '0;
            ovf       <= '0;
            for (int k = 0; k < NUM_EVT; k++) evt_cnt[k] <= '0;
        end else if (clear) begin
            cycle_cnt <= '0;
            ovf       <= '0;
            for (int k = 0; k < NUM_EVT; k++) evt_cnt[k] <= '0;
        end else if (enable) begin
            cycle_cnt <= bump(cycle_cnt);
            if (cycle_cnt == ALL_ONES) ovf[NUM_EVT] <= 1'b1;
            for (int k = 0; k < NUM_EVT; k++) begin
                if (evt_i[k]) begin
                    evt_cnt[k] <= bump(evt_cnt[k]);
                    if (evt_cnt[k] == ALL_ONES) ovf[k] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ        <= '0;
            trace_drop <= 1'b0;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ        <= '0;
            trace_drop <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (do_push && !do_pop)      occ <= occ + OCC_ONE;
            else if (do_pop && !do_push) occ <= occ - OCC_ONE;
            if (push_req && full && !do_pop) trace_drop <= 1'b1;
        end
    end

    // The timestamp is the cycle count before this edge's increment.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= {cycle_cnt, evt_i};
    end

    always_comb begin
        status           = CNT_W'(64'(ovf) | (64'(occ) << 17));
        status[CNT_W-1]  = trace_drop;
        rd_next          = '0;
        if (rd_sel == 5'd0) rd_next = cycle_cnt;
        for (int k = 0; k < NUM_EVT; k++) begin
            if (rd_sel == 5'(k + 1)) rd_next = evt_cnt[k];
        end
        if (rd_sel == SEL_STATUS) rd_next = status;
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) rd_data <= '0;
        else      rd_data <= rd_next;
    end
endmodule

// File: doc/pipe_perf_mon.md
# pipe_perf_mon

Synthesizable pipeline performance monitor that replaces simulation-only hazard printing with hardware counters and an event trace buffer. It sits beside the pipeline CPU, samples one-bit hazard strobes each cycle (stall, branch taken, forward active, flush), and keeps a free-running cycle counter and one event counter per channel. It also captures timestamped event records in a FIFO and exposes everything through a select/readout port matching the existing register-debug style.

## Interface
- NUM_EVT, 4, number of event channels; bit order stall, branch, forward, flush, then user channels; 1..16
- CNT_W, 32, width of the cycle counter, event counters and timestamps; 8..32
- TRACE_DEPTH, 16, trace FIFO entries; power of two, ≥2
- SATURATE, 0, counter overflow mode: 0 wraps to 0, 1 holds at all-ones
- clk  input  1  system clock, all state updates on rising edge
- rstn  input  1  reset, asynchronous, active-high (1 = in reset)
- enable  input  1  counting/capture enable; 0 freezes all counters and trace pushes
- clear  input  1  synchronous clear of counters, sticky flags and trace FIFO
- evt_i  input  NUM_EVT  per-cycle event strobes, sampled on clk
- rd_sel  input  5  readout select
- rd_data  output  CNT_W  registered readout word
- trace_valid  output  1  FIFO non-empty; head record valid
- trace_ready  input  1  consumer pops head when trace_valid && trace_ready
- trace_cycle  output  CNT_W  head record timestamp
- trace_evt  output  NUM_EVT  head record event mask
- trace_drop  output  1  sticky: at least one record was lost to a full FIFO

## Operation
- Cycle counter: +1 per edge while enable=1.
- Event counter k: +1 per edge while enable=1 and evt_i[k]=1; all channels count independently in the same cycle.
- Overflow: SATURATE=0 wraps all-ones→0; SATURATE=1 holds all-ones. Either way sets sticky ovf[k] (bit NUM_EVT for cycle counter).
- clear=1: all counters, ovf bits, trace_drop and FIFO pointers go to 0 on that edge; clear beats increment, push and pop in the same cycle.
- Trace push: when enable=1 and evt_i≠0, push {cycle counter value before this edge's increment, evt_i}.
- Full FIFO with push and no pop: record dropped, trace_drop←1. Full with push and pop same cycle: both occur, no drop. Pop when empty: ignored.
- FIFO is first-word-fall-through; trace_cycle/trace_evt hold head contents whenever trace_valid=1, otherwise 0.
- Readout map: 0 = cycle counter; 1..NUM_EVT = event counter rd_sel−1; NUM_EVT+1 = status {ovf[NUM_EVT:0] in low bits, trace occupancy at bit 17 up, trace_drop at bit CNT_W−1}, truncated to CNT_W; any other rd_sel = 0.

## Timing
- Reset (rstn=1, asynchronous): all counters 0, ovf 0, FIFO empty, rd_data=0, trace_valid=0, trace_cycle=0, trace_evt=0, trace_drop=0. Reset asserted mid-operation clears state immediately, without waiting for clk.
- First count occurs on the first rising edge with rstn=0 and enable=1.
- rd_data is registered: rd_sel applied before edge N returns the value the selected register held before edge N (one-cycle latency). It never shows that edge's increment.
- Pushed record becomes visible on trace_valid the edge after capture. A pop takes effect on the edge where trace_valid && trace_ready. The next head appears combinationally after that edge.
- Occupancy counts 0..TRACE_DEPTH; pointers wrap modulo TRACE_DEPTH.

## Test plan
- Reset then enable=1 for 10 cycles, evt_i=0 → rd_sel=0 reads 10; rd_sel=1..4 read 0; trace_valid=0.
- evt_i=4'b0101 for 3 cycles starting at cycle counter 5 → counters stall=3, forward=3, branch=0. Three records with trace_cycle 5,6,7 and trace_evt 0101 pop in order.
- trace_ready=0, evt_i=4'b0001 for 20 cycles, TRACE_DEPTH=16 → occupancy 16, trace_drop=1, stall counter 20. Then a push and pop in the same cycle while full leaves occupancy 16 with no further drop.
- CNT_W=8, event held 260 cycles → SATURATE=0 reads 4 with ovf set; SATURATE=1 reads 255 with ovf set.
- clear asserted in the same cycle as evt_i=4'b1111 and a pop → next cycle all counters 0, FIFO empty, trace_drop=0.
- Assert rstn asynchronously between edges mid-run → all outputs 0 before the next clk edge. Counting resumes from 0 after release.
